// File: rtl/mem_if_pkg.sv
// Shared types and default widths for the mem_responder handshake slave.
package mem_if_pkg;

    localparam int DEFAULT_ADDR_WIDTH    = 16;
    localparam int DEFAULT_DATABUS_WIDTH = 32;
    localparam int DEFAULT_DEPTH         = 1024;
    localparam int DEFAULT_LATENCY       = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_resp_sram.sv
// Single-port word storage: synchronous write, registered read-before-write, array never reset.
module mem_resp_sram
    import mem_if_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATABUS_WIDTH,
    parameter  int DEPTH      = DEFAULT_DEPTH,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = mem_q[addr];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: captures a request, answers after LATENCY cycles, holds mem_ready until mem_sel drops.
// Define MEM_RESP_RANGE_CHECK_EN to reject addresses >= DEPTH and expose the sticky err port.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
    parameter int DATABUS_WIDTH = DEFAULT_DATABUS_WIDTH,
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int LATENCY       = DEFAULT_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_sel,
    input  logic                     mem_w,
    output logic                     mem_ready,
    input  logic [ADDR_WIDTH-1:0]    addr_bus,
    inout  wire  [DATABUS_WIDTH-1:0] data_bus
`ifdef MEM_RESP_RANGE_CHECK_EN
    ,
    output logic                     err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     w_q, w_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATABUS_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATABUS_WIDTH-1:0] rdata_q, rdata_d;
    logic                     ready_q, ready_d;
`ifdef MEM_RESP_RANGE_CHECK_EN
    logic                     err_q, err_d;
`endif

    logic                     in_range;
    logic                     sram_we;
    logic [IDX_W-1:0]         sram_addr;
    logic [DATABUS_WIDTH-1:0] sram_rdata;

`ifdef MEM_RESP_RANGE_CHECK_EN
    assign in_range = ({1'b0, addr_q} < (ADDR_WIDTH + 1)'(DEPTH));
`else
    logic unused_addr_bits;
    assign in_range         = 1'b1;
    assign unused_addr_bits = ^addr_q;
`endif

    // Reading the live bus in IDLE makes the word ready one edge after capture, so LATENCY=1 works.
    assign sram_addr = (state_q == IDLE) ? addr_bus[IDX_W-1:0] : addr_q[IDX_W-1:0];

    mem_resp_sram #(
        .DATA_WIDTH (DATABUS_WIDTH),
        .DEPTH      (DEPTH)
    ) u_sram (
        .clk   (clk),
        .we    (sram_we),
        .addr  (sram_addr),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = ready_q;
        sram_we = 1'b0;
`ifdef MEM_RESP_RANGE_CHECK_EN
        err_d   = err_q;
`endif

        case (state_q)
            IDLE: begin
                ready_d = 1'b0;
                if (mem_sel) begin
                    w_d     = mem_w;
                    addr_d  = addr_bus;
                    wdata_d = data_bus;
                    cnt_d   = CNT_LOAD;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!mem_sel) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    // Reset on this edge must cancel the commit even though the FSM logic is combinational.
                    sram_we = w_q && in_range && rst;
                    if (!w_q) begin
                        rdata_d = in_range ? sram_rdata : '0;
                    end
`ifdef MEM_RESP_RANGE_CHECK_EN
                    if (!in_range) begin
                        err_d = 1'b1;
                    end
`endif
                    ready_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (!mem_sel) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ready_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
`ifdef MEM_RESP_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
`ifdef MEM_RESP_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign mem_ready = ready_q;
    assign data_bus  = (ready_q && !w_q) ? rdata_q : {DATABUS_WIDTH{1'bz}};
`ifdef MEM_RESP_RANGE_CHECK_EN
    assign err       = err_q;
`endif

endmodule
